// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
// Every operation takes a fixed 34 cycles from launch to result:
// 32 radix-2 steps in RUN, one sign-fix cycle in FIX, then IDLE.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_e;

  state_e      state_q;
  logic [1:0]  op_q;
  logic [31:0] mag_a_q, mag_b_q;
  logic        neg_a_q, neg_b_q;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q, lo_q, hi_d, lo_d;
  logic        done_q, dbz_q, dbz_d;

  logic        is_div;
  logic        a_bit;
  logic [33:0] trial;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  logic        start_neg_a, start_neg_b;

  // Operand sign flags only exist for the signed ops (op[0] == 0).
  assign start_neg_a = ~op[0] & a[31];
  assign start_neg_b = ~op[0] & b[31];

  assign is_div = op_q[1];
  assign a_bit  = mag_a_q[cnt_q];

  // One radix-2 step, MSB of |a| first: shift-add or restoring shift-subtract.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    acc_d = acc_q;
    // Divide: upper half is the partial remainder, lower half collects quotient bits.
    trial = {1'b0, acc_q[63:32], a_bit} - {2'b00, mag_b_q};
    if (is_div) begin
      if (trial[33]) acc_d = {acc_q[62:32], a_bit, acc_q[30:0], 1'b0};
      else           acc_d = {trial[31:0], acc_q[30:0], 1'b1};
    end else begin
      acc_d = {acc_q[62:0], 1'b0} + (a_bit ? {32'd0, mag_b_q} : 64'd0);
    end
  end

  // Sign correction and divide-by-zero override applied when leaving FIX.
  always_comb begin
    prod_fix = (~is_div & (neg_a_q ^ neg_b_q)) ? -acc_q : acc_q;
    quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[31:0]  : acc_q[31:0];
    rem_fix  = neg_a_q             ? -acc_q[63:32] : acc_q[63:32];
    dbz_d    = is_div & (mag_b_q == 32'd0);
    if (is_div) begin
      // With b == 0 the remainder path shifts |a| straight through, so
      // re-applying sign(a) returns the original dividend.
      hi_d = rem_fix;
      lo_d = dbz_d ? 32'hFFFF_FFFF : quo_fix;
    end else begin
      hi_d = prod_fix[63:32];
      lo_d = prod_fix[31:0];
    end
  end

  // Control FSM, datapath registers and HI/LO with their direct-write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      mag_a_q <= 32'd0;
      mag_b_q <= 32'd0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      acc_q   <= 64'd0;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // A launch takes priority over any HI/LO write in the same cycle.
            op_q    <= op;
            mag_a_q <= start_neg_a ? -a : a;
            mag_b_q <= start_neg_b ? -b : b;
            neg_a_q <= start_neg_a;
            neg_b_q <= start_neg_b;
            acc_q   <= 64'd0;
            cnt_q   <= 5'd31;
            state_q <= RUN;
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          dbz_q   <= dbz_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a transaction-level model of the
// HI/LO/busy/done behaviour compared every cycle, plus literal expectations.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0, b = 32'd0, wdata = 32'd0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, div_by_zero;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Architectural result of one operation, straight from integer arithmetic.
  function automatic void golden(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] rh, output logic [31:0] rl, output logic dz);
    longint          sx, sy, sp, sq, sr;
    longint unsigned ux, uy, up;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    dz = 1'b0;
    case (o)
      2'd0: begin sp = sx * sy; rh = sp[63:32]; rl = sp[31:0]; end
      2'd1: begin up = ux * uy; rh = up[63:32]; rl = up[31:0]; end
      default: begin
        if (y == 32'd0) begin
          rh = x; rl = 32'hFFFF_FFFF; dz = 1'b1;
        end else if (o == 2'd2) begin
          sq = sx / sy; sr = sx % sy;
          rh = sr[31:0]; rl = sq[31:0];
        end else begin
          rh = x % y; rl = x / y;
        end
      end
    endcase
  endfunction

  // Model state: what the outputs must show after each edge.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_done, m_dbz, p_dbz;
  int          m_left;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b0; m_dbz = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (m_left != 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dbz = p_dbz;
        end
      end else if (start) begin
        golden(op, a, b, p_hi, p_lo, p_dbz);
        m_left = 33;
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    check("cyc_hi", hi, m_hi);
    check("cyc_lo", lo, m_lo);
    check("cyc_busy", {31'd0, busy}, {31'd0, m_left != 0});
    check("cyc_done", {31'd0, done}, {31'd0, m_done});
    check("cyc_dbz", {31'd0, div_by_zero}, {31'd0, m_dbz});
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit same_cycle);
    if (!same_cycle) @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; counts busy cycles seen from the current negedge.
  task automatic wait_done(output int bc, output bit gd);
    bc = 0;
    gd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        gd = 1'b1;
        break;
      end
      if (busy) bc++;
      @(negedge clk);
    end
  endtask

  task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input bit same_cycle,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    int bc;
    bit gd;
    issue(o, x, y, same_cycle);
    wait_done(bc, gd);
    check({name, "_done"}, {31'd0, gd}, 32'd1);
    check({name, "_busy_cycles"}, bc, 32'd33);
    check({name, "_hi"}, hi, ehi);
    check({name, "_lo"}, lo, elo);
    check({name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edz});
  endtask

  initial begin
    int bc;
    bit gd;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    #2 reset = 1'b0;

    run_check("mult_neg2x3", 2'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    // Launched in the same cycle done is high.
    run_check("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_check("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_check("div_min_m1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_check("divu_by0", 2'd3, 32'h0000_0064, 32'h0000_0000, 1'b0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    run_check("div_neg_by0", 2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    run_check("divu_100_7", 2'd3, 32'h0000_0064, 32'h0000_0007, 1'b0, 32'h0000_0002, 32'h0000_000E, 1'b0);
    run_check("mult_min_sq", 2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_check("mult_m3_m5", 2'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b0, 32'h0000_0000, 32'h0000_000F, 1'b0);

    // Direct HI/LO writes in IDLE.
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("wr_hi", hi, 32'h1234_5678);
    check("wr_lo", lo, 32'h1234_5678);

    // start and lo_we together: the write is discarded.
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd2; b = 32'd3; lo_we = 1'b1; wdata = 32'hAAAA_5555;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    check("start_lo_discard", lo, 32'h1234_5678);
    wait_done(bc, gd);
    check("start_lo_done", {31'd0, gd}, 32'd1);
    check("start_lo_result", lo, 32'h0000_0006);

    // Reset in the middle of RUN aborts with no done.
    issue(2'd1, 32'd5, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    wait_done(bc, gd);
    check("abort_no_done", {31'd0, gd}, 32'd0);

    // Restart; writes and a second start while busy are ignored.
    issue(2'd1, 32'd5, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF; start = 1'b1; op = 2'd2; a = 32'd1; b = 32'd1;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
    check("busy_wr_ignored", hi, 32'd0);
    wait_done(bc, gd);
    check("restart_done", {31'd0, gd}, 32'd1);
    check("restart_hi", hi, 32'd0);
    check("restart_lo", lo, 32'h0000_0023);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
